// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel counters, sync pulses, active-area flag and frame pulse, gated by PLL lock.
// Latency: first (0,0) appears 3 clocks after locked rises; all outputs are registered and mutually aligned.
// No backpressure: free-running once locked; loss of lock aborts the frame and idles the outputs.
// Optional feature: define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        locked,
`ifdef VGA_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       SYNC_ON  = (SYNC_POL != 0);

  typedef enum logic {WAIT_LOCK, RUN} state_t;

  state_t     r_state, w_next_state;
  logic       r_sync1, r_sync2;
  logic [9:0] r_x, r_y, w_next_x, w_next_y;
  logic       r_hsync, r_vsync, r_video_on, r_frame_start;
  logic       w_run, w_hsync, w_vsync, w_video_on, w_frame_start;

  // Two-flop synchronizer bringing the PLL lock flag into the pixel clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= locked;
      r_sync2 <= r_sync1;
    end
  end

  // Next state: run while the synchronized lock flag is high, otherwise wait.
  always_comb begin
    w_next_state = r_state;
    if (r_state == WAIT_LOCK) begin
      if (r_sync2) w_next_state = RUN;
    end else begin
      if (!r_sync2) w_next_state = WAIT_LOCK;
    end
  end

  // Next pixel position: restart at (0,0) on entering RUN, advance raster while in RUN, zero otherwise.
  always_comb begin
    w_next_x = '0;
    w_next_y = '0;
    if (w_next_state == RUN && r_state == RUN) begin
      if (r_x == H_LAST) begin
        w_next_x = '0;
        w_next_y = (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;
      end else begin
        w_next_x = r_x + 10'd1;
        w_next_y = r_y;
      end
    end
  end

  // Decode the next position so the registered flags line up with the registered counters.
  always_comb begin
    w_run         = (w_next_state == RUN);
    w_hsync       = (w_run && w_next_x >= HS_FIRST && w_next_x <= HS_LAST) ? SYNC_ON : ~SYNC_ON;
    w_vsync       = (w_run && w_next_y >= VS_FIRST && w_next_y <= VS_LAST) ? SYNC_ON : ~SYNC_ON;
    w_video_on    = w_run && (w_next_x < H_ACT) && (w_next_y < V_ACT);
    w_frame_start = w_run && (w_next_x == 10'd0) && (w_next_y == 10'd0);
  end

  // State, counters and output flags; reset wins over any lock activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= WAIT_LOCK;
      r_x           <= '0;
      r_y           <= '0;
      r_hsync       <= ~SYNC_ON;
      r_vsync       <= ~SYNC_ON;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_x           <= w_next_x;
      r_y           <= w_next_y;
      r_hsync       <= w_hsync;
      r_vsync       <= w_vsync;
      r_video_on    <= w_video_on;
      r_frame_start <= w_frame_start;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Frame counter counts every frame_start pulse (including the one now shown); only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_frame_start) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size 640x480 instance for line timing and a small
// active-high-sync instance (32x20 raster) so whole frames fit in a short run.
module tb_vga_sync_gen;

  // Small raster: H 16+4+8+4 = 32, V 12+2+2+4 = 20, frame = 640 clocks.
  localparam int SH_A = 16, SH_F = 4, SH_S = 8, SH_B = 4;
  localparam int SV_A = 12, SV_F = 2, SV_S = 2, SV_B = 4;

  logic       clk;
  logic       rst;
  logic       lk_d, lk_s;
  logic       hs_d, vs_d, vo_d, fs_d;
  logic       hs_s, vs_s, vo_s, fs_s;
  logic [9:0] x_d, y_d, x_s, y_s;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fc_d, fc_s;
`endif

  int n_cmp = 0;
  int n_err = 0;

  vga_sync_gen dut_d (
    .clk(clk), .rst(rst), .locked(lk_d),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt(fc_d),
`endif
    .hsync(hs_d), .vsync(vs_d), .video_on(vo_d),
    .pixel_x(x_d), .pixel_y(y_d), .frame_start(fs_d)
  );

  vga_sync_gen #(
    .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
    .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
    .SYNC_POL(1)
  ) dut_s (
    .clk(clk), .rst(rst), .locked(lk_s),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt(fc_s),
`endif
    .hsync(hs_s), .vsync(vs_s), .video_on(vo_s),
    .pixel_x(x_s), .pixel_y(y_s), .frame_start(fs_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Expected {hsync,vsync,video_on,frame_start,x,y} for a raster position given as a
  // running pixel index since the start of RUN.
  function automatic logic [23:0] expv(input bit run, input int idx,
                                       input int ha, input int hf, input int hsw, input int hb,
                                       input int va, input int vf, input int vsw, input int vb,
                                       input bit pol);
    int  ht, vt, x, y;
    bit  hact, vact, von, fs;
    if (!run) return {~pol, ~pol, 2'b00, 20'd0};
    ht   = ha + hf + hsw + hb;
    vt   = va + vf + vsw + vb;
    x    = idx % ht;
    y    = (idx / ht) % vt;
    hact = (x >= ha + hf) && (x < ha + hf + hsw);
    vact = (y >= va + vf) && (y < va + vf + vsw);
    von  = (x < ha) && (y < va);
    fs   = (x == 0) && (y == 0);
    return {hact ? pol : ~pol, vact ? pol : ~pol, von, fs, 10'(x), 10'(y)};
  endfunction

  // Model: outputs are in RUN at edge n iff locked was 1 at edge n-2 and rst was low at
  // edges n-2, n-1 and n; the raster index counts consecutive RUN edges from 0.
  bit          lk1[2], lk2[2], mrun[2];
  bit          rs1, rs2, started;
  int          midx[2];
  logic [15:0] mfc[2];
  int          ftot[2];

  initial begin
    ftot[0] = 800 * 525;
    ftot[1] = (SH_A + SH_F + SH_S + SH_B) * (SV_A + SV_F + SV_S + SV_B);
    mfc[0]  = '0;
    mfc[1]  = '0;
  end

  always @(posedge clk) begin
    bit lin[2];
    bit r;
    lin[0] = lk_d;
    lin[1] = lk_s;
    for (int k = 0; k < 2; k++) begin
      r       = lk2[k] && !rs2 && !rs1 && !rst;
      midx[k] = r ? (mrun[k] ? midx[k] + 1 : 0) : 0;
      mrun[k] = r;
      if (rst) mfc[k] = '0;
      else if (r && (midx[k] % ftot[k] == 0)) mfc[k] = mfc[k] + 16'd1;
      lk2[k] = lk1[k];
      lk1[k] = lin[k];
    end
    rs2     = rs1;
    rs1     = rst;
    started = 1'b1;
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("model_d", {8'd0, hs_d, vs_d, vo_d, fs_d, x_d, y_d},
          {8'd0, expv(mrun[0], midx[0], 640, 16, 96, 48, 480, 10, 2, 33, 1'b0)});
      chk("model_s", {8'd0, hs_s, vs_s, vo_s, fs_s, x_s, y_s},
          {8'd0, expv(mrun[1], midx[1], SH_A, SH_F, SH_S, SH_B, SV_A, SV_F, SV_S, SV_B, 1'b1)});
`ifdef VGA_FRAME_CNT_EN
      chk("model_fc_d", {16'd0, fc_d}, {16'd0, mfc[0]});
      chk("model_fc_s", {16'd0, fc_s}, {16'd0, mfc[1]});
`endif
    end
  end

  initial begin
    int cnt_hs, first_hs, last_hs, first_off, per, vcnt, nfs;
    bit found;

    rst  = 1'b1;
    lk_d = 1'b0;
    lk_s = 1'b0;

    // Reset with lock low: idle levels throughout.
    repeat (4) begin
      @(negedge clk);
      chk("rst_idle_d", {8'd0, hs_d, vs_d, vo_d, fs_d, x_d, y_d}, 32'h00C0_0000);
      chk("rst_idle_s", {8'd0, hs_s, vs_s, vo_s, fs_s, x_s, y_s}, 32'h0000_0000);
    end
    rst = 1'b0;
    @(negedge clk);
    lk_d = 1'b1;
    lk_s = 1'b1;

    // First (0,0) exactly three clocks after locked rises.
    @(negedge clk);
    chk("lock_c1_vo", vo_d, 0);
    @(negedge clk);
    chk("lock_c2_fs", fs_d, 0);
    @(negedge clk);
    chk("lock_c3_origin", {fs_d, vo_d, hs_d, x_d, y_d}, {3'b111, 20'd0});

    // One full line of the 640x480 instance.
    cnt_hs = 0; first_hs = -1; last_hs = -1; first_off = -1; found = 0;
    for (int i = 0; i < 900 && !found; i++) begin
      @(negedge clk);
      if (x_d == 0 && y_d == 1) found = 1;
      else begin
        if (!hs_d) begin
          cnt_hs++;
          if (first_hs < 0) first_hs = int'(x_d);
          last_hs = int'(x_d);
        end
        if (!vo_d && first_off < 0) first_off = int'(x_d);
      end
    end
    chk("line_wrap_seen", found, 1);
    chk("line_hs_count", cnt_hs, 96);
    chk("line_hs_first", first_hs, 656);
    chk("line_hs_last", last_hs, 751);
    chk("line_vo_off_x", first_off, 640);

    // Frame period and vsync width on the small instance (active-high sync).
    found = 0;
    for (int i = 0; i < 700 && !found; i++) begin
      @(negedge clk);
      if (fs_s) found = 1;
    end
    chk("frame_fs_seen", found, 1);
    per = 0; vcnt = 0; found = 0;
    for (int i = 0; i < 700 && !found; i++) begin
      @(negedge clk);
      per++;
      if (vs_s) vcnt++;
      if (fs_s) found = 1;
    end
    chk("frame_fs_again", found, 1);
    chk("frame_period", per, 640);
    chk("frame_vs_count", vcnt, 64);

    // Drop lock mid-frame at (20,7).
    found = 0;
    for (int i = 0; i < 700 && !found; i++) begin
      @(negedge clk);
      if (x_s == 20 && y_s == 7) found = 1;
    end
    chk("drop_pos_seen", found, 1);
    lk_s = 1'b0;
    @(negedge clk);
    chk("drop_c1_x", x_s, 21);
    @(negedge clk);
    chk("drop_c2_pos", {x_s, y_s}, {10'd22, 10'd7});
    @(negedge clk);
    chk("drop_c3_idle", {hs_s, vs_s, vo_s, fs_s, x_s, y_s}, 0);
    repeat (5) @(negedge clk);
    chk("drop_hold_idle", {hs_s, vs_s, vo_s, fs_s, x_s, y_s}, 0);
    lk_s = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("relock_c2_idle", fs_s, 0);
    @(negedge clk);
    chk("relock_c3_origin", {fs_s, x_s, y_s}, {1'b1, 20'd0});

    // Reset mid-frame: idle values on the following cycle, then automatic restart.
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_idle_d", {8'd0, hs_d, vs_d, vo_d, fs_d, x_d, y_d}, 32'h00C0_0000);
    chk("midrst_idle_s", {8'd0, hs_s, vs_s, vo_s, fs_s, x_s, y_s}, 32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst_relock_fs", {fs_d, fs_s}, 2'b11);

`ifdef VGA_FRAME_CNT_EN
    // Three frames from reset gives frame_cnt = 3; rst clears it next cycle.
    nfs = 1; found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (fs_s) nfs++;
      if (nfs == 3) found = 1;
    end
    chk("fc_three_seen", found, 1);
    chk("fc_three", fc_s, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("fc_rst_clear", fc_s, 0);
    rst = 1'b0;
`else
    nfs = 0;
`endif

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
